rom_sync: RTL and testbench

- Read-only lookup memory of 2^ADDR_BITS words of DATA_BITS each, with NUM_PORTS independent read ports.
- Contents are fixed at elaboration in the same form a ROM generator tool emits: a constant case/array table.
- Used as a constant table, e.g. character glyphs or microcode, by synchronous logic in one clock domain.
- Reads are registered, with one-cycle latency.

---
 rtl/rom_sync.sv | 75 +++++++
 tb/tb_rom_sync.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rom_sync.sv
// rom_sync: read-only lookup table of 2^ADDR_BITS words x DATA_BITS bits,
// with NUM_PORTS independent read ports and registered output. The read
// latency is one cycle.
//
// Contents are fixed when the design is built: word[a] = 1 << (a mod DATA_BITS),
// truncated to DATA_BITS. For the default 8x8 configuration the table holds
// 0x01, 0x02, 0x04, ... 0x80 for addresses 0..7.
//
// Ports:
//   in_clk     clock; all state changes on the rising edge
//   in_rst     synchronous reset, active low
//   in_addr    packed read addresses; port p uses [p*ADDR_BITS +: ADDR_BITS]
//   in_rd_en   per-port read enable
//   out_data   packed read data; port p uses [p*DATA_BITS +: DATA_BITS].
//              It keeps its last value while the port is idle.
//   out_valid  per-port flag: out_data holds the result of a read that was
//              enabled on the previous edge
module rom_sync #(
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_PORTS = 1
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] in_addr,
  input  logic [NUM_PORTS-1:0]           in_rd_en,
  output logic [NUM_PORTS*DATA_BITS-1:0] out_data,
  output logic [NUM_PORTS-1:0]           out_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef logic [DATA_BITS-1:0] word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  // Constant contents generator, evaluated at elaboration.
  function automatic word_t rom_word(input int unsigned a);
    return word_t'(1) << (a % DATA_BITS);
  endfunction

  // Constant table shared by all ports. Every address value selects an
  // entry, so there is no out-of-range case.
  word_t rom_table [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    assign rom_table[i] = rom_word(i);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    addr_t addr;
    word_t data_q;
    logic  valid_q;

    assign addr = in_addr[p*ADDR_BITS +: ADDR_BITS];

    // Reset takes priority over a read in the same cycle. The table is
    // only indexed when the port is enabled, so an unknown address on an
    // idle port cannot reach the output register.
    always_ff @(posedge in_clk) begin
      if (!in_rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_rd_en[p];
        if (in_rd_en[p]) begin
          data_q <= rom_table[addr];
        end
      end
    end

    assign out_data[p*DATA_BITS +: DATA_BITS] = data_q;
    assign out_valid[p]                       = valid_q;
  end

endmodule

// File: tb/tb_rom_sync.sv
module tb_rom_sync;

  localparam int unsigned AB = 3;
  localparam int unsigned DB = 8;
  localparam int unsigned NP = 2;

  logic              clk;
  logic              rst;
  logic [NP*AB-1:0]  addr;
  logic [NP-1:0]     rd_en;
  logic [NP*DB-1:0]  data;
  logic [NP-1:0]     valid;

  int unsigned n_checks;
  int unsigned n_pass;

  rom_sync #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .NUM_PORTS(NP)
  ) dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_addr  (addr),
    .in_rd_en (rd_en),
    .out_data (data),
    .out_valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst;
    logic [NP-1:0]    en;
    logic [AB-1:0]    a1;
    logic [AB-1:0]    a0;
    logic [NP*DB-1:0] exp_data;
    logic [NP-1:0]    exp_valid;
  } vec_t;

  vec_t vecs [$];

  task automatic check_data(input string name, input logic [NP*DB-1:0] exp_d);
    n_checks++;
    if (data === exp_d) n_pass++;
    else $display("FAIL %s data: got %h expected %h", name, data, exp_d);
  endtask

  task automatic check_valid(input string name, input logic [NP-1:0] exp_v);
    n_checks++;
    if (valid === exp_v) n_pass++;
    else $display("FAIL %s valid: got %b expected %b", name, valid, exp_v);
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [NP-1:0] en,
                      input logic [AB-1:0] a1, input logic [AB-1:0] a0);
    rst   = r;
    rd_en = en;
    addr  = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    rd_en    = '0;
    addr     = '0;

    //          name          rst  en     a1    a0    data      valid
    vecs.push_back('{"rst_hold0", 1'b0, 2'b01, 3'd0, 3'd5, 16'h0000, 2'b00});
    vecs.push_back('{"rst_hold1", 1'b0, 2'b01, 3'd0, 3'd5, 16'h0000, 2'b00});
    vecs.push_back('{"seq_a0",    1'b1, 2'b01, 3'd0, 3'd0, 16'h0001, 2'b01});
    vecs.push_back('{"seq_a1",    1'b1, 2'b01, 3'd0, 3'd1, 16'h0002, 2'b01});
    vecs.push_back('{"seq_a2",    1'b1, 2'b01, 3'd0, 3'd2, 16'h0004, 2'b01});
    vecs.push_back('{"seq_a3",    1'b1, 2'b01, 3'd0, 3'd3, 16'h0008, 2'b01});
    vecs.push_back('{"sweep_a4",  1'b1, 2'b01, 3'd0, 3'd4, 16'h0010, 2'b01});
    vecs.push_back('{"sweep_a5",  1'b1, 2'b01, 3'd0, 3'd5, 16'h0020, 2'b01});
    vecs.push_back('{"sweep_a6",  1'b1, 2'b01, 3'd0, 3'd6, 16'h0040, 2'b01});
    vecs.push_back('{"sweep_a7",  1'b1, 2'b01, 3'd0, 3'd7, 16'h0080, 2'b01});
    vecs.push_back('{"bound_a0",  1'b1, 2'b01, 3'd0, 3'd0, 16'h0001, 2'b01});
    vecs.push_back('{"hold_rd6",  1'b1, 2'b01, 3'd0, 3'd6, 16'h0040, 2'b01});
    vecs.push_back('{"hold_idle", 1'b1, 2'b00, 3'd0, 3'd2, 16'h0040, 2'b00});
    vecs.push_back('{"mp_same3",  1'b1, 2'b11, 3'd3, 3'd3, 16'h0808, 2'b11});
    vecs.push_back('{"mp_1_7",    1'b1, 2'b11, 3'd7, 3'd1, 16'h8002, 2'b11});
    vecs.push_back('{"p1_only",   1'b1, 2'b10, 3'd5, 3'd0, 16'h2002, 2'b10});
    vecs.push_back('{"rst_mid",   1'b1, 2'b00, 3'd0, 3'd0, 16'h2002, 2'b00});
    vecs.push_back('{"rst_rd4",   1'b0, 2'b01, 3'd0, 3'd4, 16'h0000, 2'b00});
    vecs.push_back('{"post_rst4", 1'b1, 2'b01, 3'd0, 3'd4, 16'h0010, 2'b01});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].a1, vecs[i].a0);
      check_data(vecs[i].name, vecs[i].exp_data);
      check_valid(vecs[i].name, vecs[i].exp_valid);
    end

    // Unknown address on idle ports must not disturb held data.
    rst   = 1'b1;
    rd_en = 2'b11;
    addr  = {3'd7, 3'd2};
    @(posedge clk);
    #1;
    check_data("x_setup", 16'h8004);
    rd_en = 2'b00;
    addr  = 'x;
    @(posedge clk);
    #1;
    check_data("x_idle_data", 16'h8004);
    check_valid("x_idle_valid", 2'b00);

    // Back-to-back on both ports, one result per cycle, opposite sweep order.
    for (int unsigned k = 0; k < 8; k++) begin
      logic [AB-1:0] ka;
      logic [AB-1:0] kb;
      logic [DB-1:0] ea;
      logic [DB-1:0] eb;
      ka = AB'(k);
      kb = AB'(7 - k);
      ea = DB'(1) << k;
      eb = DB'(1) << (7 - k);
      step(1'b1, 2'b11, kb, ka);
      check_data($sformatf("b2b_%0d", k), {eb, ea});
      check_valid($sformatf("b2b_%0d", k), 2'b11);
    end

    // Reset with reads pending on both ports, then release.
    step(1'b0, 2'b11, 3'd6, 3'd1);
    check_data("rst_both", 16'h0000);
    check_valid("rst_both", 2'b00);
    step(1'b1, 2'b10, 3'd6, 3'd1);
    check_data("after_rst_p1", 16'h4000);
    check_valid("after_rst_p1", 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
